// File: rtl/i2c_arbiter.sv
// Two-requester round-robin arbiter in front of a single-byte I2C master.
// One transaction at a time: arbitrate, launch, wait for done or timeout, respond, then idle the bus.
module i2c_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int GAP_CYCLES     = 4
) (
    input  logic        clk_400,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_rw,
    input  logic [13:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_ack_error,
    output logic        rsp_timeout,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        m_start_txn,
    output logic        m_rw,
    output logic        m_data_valid,
    output logic        m_next_byte,
    output logic [6:0]  m_sub_addr,
    output logic [7:0]  m_data_in,
    input  logic        m_done,
    input  logic        m_ack_error,
    input  logic [7:0]  m_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        RESPOND,
        GAP
    } state_t;

    state_t      state;
    logic        last_grant;
    logic        owner;
    logic        win_idx;
    logic        lat_rw;
    logic [6:0]  lat_addr;
    logic [7:0]  lat_wdata;
    logic [15:0] timer;
    logic [7:0]  gap_cnt;
    logic [7:0]  cap_rdata;
    logic        cap_ack_error;
    logic        cap_timeout;

    assign m_next_byte = 1'b0;

    // With both requesting, the one that did not own the previous transaction wins.
    always_comb begin
        win_idx = 1'b0;
        if (req_valid == 2'b11)
            win_idx = ~last_grant;
        else if (req_valid[1])
            win_idx = 1'b1;
    end

    always_ff @(posedge clk_400 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            lat_rw        <= 1'b0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            timer         <= '0;
            gap_cnt       <= '0;
            cap_rdata     <= '0;
            cap_ack_error <= 1'b0;
            cap_timeout   <= 1'b0;
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_ack_error <= 1'b0;
            rsp_timeout   <= 1'b0;
            grant         <= '0;
            busy          <= 1'b0;
            m_start_txn   <= 1'b0;
            m_rw          <= 1'b0;
            m_data_valid  <= 1'b0;
            m_sub_addr    <= '0;
            m_data_in     <= '0;
        end else begin
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_ack_error <= 1'b0;
            rsp_timeout   <= 1'b0;
            m_start_txn   <= 1'b0;
            m_data_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        owner     <= win_idx;
                        lat_rw    <= win_idx ? req_rw[1] : req_rw[0];
                        lat_addr  <= win_idx ? req_addr[13:7] : req_addr[6:0];
                        lat_wdata <= win_idx ? req_wdata[15:8] : req_wdata[7:0];
                        req_ready <= win_idx ? 2'b10 : 2'b01;
                        grant     <= win_idx ? 2'b10 : 2'b01;
                        busy      <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    m_start_txn  <= 1'b1;
                    m_data_valid <= ~lat_rw;
                    m_rw         <= lat_rw;
                    m_sub_addr   <= lat_addr;
                    m_data_in    <= lat_wdata;
                    timer        <= '0;
                    state        <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A done arriving on the timeout cycle still counts as a completion.
                    if (m_done) begin
                        cap_ack_error <= m_ack_error;
                        cap_rdata     <= (lat_rw && !m_ack_error) ? m_data_out : 8'h00;
                        cap_timeout   <= 1'b0;
                        m_rw          <= 1'b0;
                        m_sub_addr    <= '0;
                        m_data_in     <= '0;
                        state         <= RESPOND;
                    end else if (timer == 16'(TIMEOUT_CYCLES - 1)) begin
                        cap_ack_error <= 1'b0;
                        cap_rdata     <= 8'h00;
                        cap_timeout   <= 1'b1;
                        m_rw          <= 1'b0;
                        m_sub_addr    <= '0;
                        m_data_in     <= '0;
                        state         <= RESPOND;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RESPOND: begin
                    rsp_valid     <= owner ? 2'b10 : 2'b01;
                    rsp_rdata     <= cap_rdata;
                    rsp_ack_error <= cap_ack_error;
                    rsp_timeout   <= cap_timeout;
                    last_grant    <= owner;
                    gap_cnt       <= '0;
                    state         <= GAP;
                end
                GAP: begin
                    grant <= '0;
                    if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter; the bench plays both requesters and the I2C master.
module tb_i2c_arbiter;

    localparam int TIMEOUT = 60;
    localparam int GAP     = 4;

    logic        clk_400;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_rw;
    logic [13:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_ack_error;
    logic        rsp_timeout;
    logic [1:0]  grant;
    logic        busy;
    logic        m_start_txn;
    logic        m_rw;
    logic        m_data_valid;
    logic        m_next_byte;
    logic [6:0]  m_sub_addr;
    logic [7:0]  m_data_in;
    logic        m_done;
    logic        m_ack_error;
    logic [7:0]  m_data_out;

    int checks;
    int failures;
    int cyc;

    i2c_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .GAP_CYCLES(GAP)) dut (
        .clk_400(clk_400),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_rw(req_rw),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_ack_error(rsp_ack_error),
        .rsp_timeout(rsp_timeout),
        .grant(grant),
        .busy(busy),
        .m_start_txn(m_start_txn),
        .m_rw(m_rw),
        .m_data_valid(m_data_valid),
        .m_next_byte(m_next_byte),
        .m_sub_addr(m_sub_addr),
        .m_data_in(m_data_in),
        .m_done(m_done),
        .m_ack_error(m_ack_error),
        .m_data_out(m_data_out)
    );

    initial clk_400 = 1'b0;
    always #5 clk_400 = ~clk_400;

    initial cyc = 0;
    always @(posedge clk_400) cyc <= cyc + 1;

    function automatic logic [63:0] allOutputs();
        return 64'({req_ready, rsp_valid, rsp_rdata, rsp_ack_error, rsp_timeout, grant, busy,
                    m_start_txn, m_rw, m_data_valid, m_next_byte, m_sub_addr, m_data_in});
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic valid, input logic rw,
                                 input logic [6:0] addr, input logic [7:0] wdata);
        req_valid[idx]          = valid;
        req_rw[idx]             = rw;
        req_addr[idx*7 +: 7]    = addr;
        req_wdata[idx*8 +: 8]   = wdata;
    endtask

    // sel: 0 = req_ready, 1 = m_start_txn, 2 = rsp_valid, 3 = bus idle
    task automatic waitFor(input int sel, input int limit, input string tag);
        int  n;
        bit  hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            @(negedge clk_400);
            n++;
            case (sel)
                0:       hit = |req_ready;
                1:       hit = m_start_txn;
                2:       hit = |rsp_valid;
                default: hit = !busy;
            endcase
        end
        checkOutput({tag, "_seen"}, 64'(hit), 64'd1);
    endtask

    // Waits delay cycles, pulses m_done, and returns on the cycle the response should be visible.
    task automatic completeTxn(input int delay, input logic nack, input logic [7:0] rdata);
        repeat (delay) @(negedge clk_400);
        m_done      = 1'b1;
        m_ack_error = nack;
        m_data_out  = rdata;
        @(negedge clk_400);
        m_done      = 1'b0;
        m_ack_error = 1'b0;
        m_data_out  = 8'h00;
        @(negedge clk_400);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start_cyc;
        int rsp_cyc;
        bit saw_rsp;
        logic [1:0] exp_grant [4];
        exp_grant[0] = 2'b01;
        exp_grant[1] = 2'b10;
        exp_grant[2] = 2'b01;
        exp_grant[3] = 2'b10;
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b1;
        req_valid   = '0;
        req_rw      = '0;
        req_addr    = '0;
        req_wdata   = '0;
        m_done      = 1'b0;
        m_ack_error = 1'b0;
        m_data_out  = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk_400);
        checkOutput("reset_outputs", allOutputs(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk_400);
        checkOutput("idle_after_reset", allOutputs(), 64'd0);

        // Write from requester 0
        applyStimulus(0, 1'b1, 1'b0, 7'h50, 8'hA5);
        waitFor(0, 20, "wr_ready");
        checkOutput("wr_ready", 64'(req_ready), 64'h1);
        checkOutput("wr_grant", 64'(grant), 64'h1);
        checkOutput("wr_busy", 64'(busy), 64'h1);
        applyStimulus(0, 1'b0, 1'b0, 7'h00, 8'h00);
        @(negedge clk_400);
        checkOutput("wr_start", 64'(m_start_txn), 64'h1);
        checkOutput("wr_launch", 64'({m_rw, m_data_valid, m_sub_addr, m_data_in}),
                    64'({1'b0, 1'b1, 7'h50, 8'hA5}));
        repeat (39) @(negedge clk_400);
        checkOutput("wr_hold", 64'({m_start_txn, m_data_valid, m_sub_addr, m_data_in}),
                    64'({1'b0, 1'b0, 7'h50, 8'hA5}));
        completeTxn(1, 1'b0, 8'hFF);
        checkOutput("wr_rsp", 64'({rsp_valid, rsp_rdata, rsp_ack_error, rsp_timeout}),
                    64'({2'b01, 8'h00, 1'b0, 1'b0}));
        @(negedge clk_400);
        checkOutput("wr_rsp_clear", 64'({rsp_valid, rsp_rdata, grant}), 64'd0);
        waitFor(3, 20, "wr_idle");

        // Read from requester 1
        applyStimulus(1, 1'b1, 1'b1, 7'h3C, 8'h99);
        waitFor(0, 20, "rd_ready");
        checkOutput("rd_ready", 64'(req_ready), 64'h2);
        applyStimulus(1, 1'b0, 1'b0, 7'h00, 8'h00);
        @(negedge clk_400);
        checkOutput("rd_launch", 64'({m_start_txn, m_rw, m_data_valid, m_sub_addr}),
                    64'({1'b1, 1'b1, 1'b0, 7'h3C}));
        completeTxn(6, 1'b0, 8'h5E);
        checkOutput("rd_rsp", 64'({rsp_valid, rsp_rdata, rsp_ack_error, rsp_timeout}),
                    64'({2'b10, 8'h5E, 1'b0, 1'b0}));
        waitFor(3, 20, "rd_idle");

        // Round-robin from a fresh reset
        rst_n = 1'b0;
        @(negedge clk_400);
        rst_n = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 7'h10, 8'h01);
        applyStimulus(1, 1'b1, 1'b0, 7'h20, 8'h02);
        rsp_cyc = -100;
        for (int t = 0; t < 4; t++) begin
            waitFor(0, 40, "rr_ready");
            checkOutput($sformatf("rr_grant%0d", t), 64'(grant), 64'(exp_grant[t]));
            if (t > 0)
                checkOutput($sformatf("rr_spacing%0d", t), 64'(cyc - rsp_cyc >= GAP + 1), 64'd1);
            if (t == 3)
                req_valid = 2'b00;
            @(negedge clk_400);
            completeTxn(3, 1'b0, 8'h00);
            checkOutput($sformatf("rr_rsp%0d", t), 64'(rsp_valid), 64'(exp_grant[t]));
            rsp_cyc = cyc;
        end
        waitFor(3, 20, "rr_idle");

        // NACK on a read
        applyStimulus(0, 1'b1, 1'b1, 7'h22, 8'h00);
        waitFor(0, 20, "nack_ready");
        applyStimulus(0, 1'b0, 1'b0, 7'h00, 8'h00);
        @(negedge clk_400);
        completeTxn(5, 1'b1, 8'hAB);
        checkOutput("nack_rsp", 64'({rsp_valid, rsp_rdata, rsp_ack_error, rsp_timeout}),
                    64'({2'b01, 8'h00, 1'b1, 1'b0}));
        waitFor(3, 20, "nack_idle");

        // Timeout with no m_done
        applyStimulus(0, 1'b1, 1'b0, 7'h33, 8'h44);
        waitFor(0, 20, "to_ready");
        applyStimulus(0, 1'b0, 1'b0, 7'h00, 8'h00);
        waitFor(1, 5, "to_start");
        start_cyc = cyc;
        waitFor(2, TIMEOUT + 20, "to_rsp");
        checkOutput("to_latency", 64'(cyc - start_cyc), 64'(TIMEOUT + 1));
        checkOutput("to_rsp", 64'({rsp_valid, rsp_rdata, rsp_ack_error, rsp_timeout}),
                    64'({2'b01, 8'h00, 1'b0, 1'b1}));
        waitFor(3, 20, "to_idle");

        // m_done on the timeout cycle wins
        applyStimulus(0, 1'b1, 1'b1, 7'h11, 8'h00);
        waitFor(0, 20, "tod_ready");
        applyStimulus(0, 1'b0, 1'b0, 7'h00, 8'h00);
        waitFor(1, 5, "tod_start");
        start_cyc = cyc;
        completeTxn(TIMEOUT - 1, 1'b0, 8'h77);
        checkOutput("tod_latency", 64'(cyc - start_cyc), 64'(TIMEOUT + 1));
        checkOutput("tod_rsp", 64'({rsp_valid, rsp_rdata, rsp_ack_error, rsp_timeout}),
                    64'({2'b01, 8'h77, 1'b0, 1'b0}));
        waitFor(3, 20, "tod_idle");

        // Reset in the middle of WAIT_DONE
        applyStimulus(1, 1'b1, 1'b1, 7'h44, 8'h00);
        waitFor(0, 20, "rst_ready");
        applyStimulus(1, 1'b0, 1'b0, 7'h00, 8'h00);
        repeat (5) @(negedge clk_400);
        checkOutput("rst_busy_before", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 checkOutput("rst_outputs", allOutputs(), 64'd0);
        @(negedge clk_400);
        rst_n       = 1'b1;
        m_done      = 1'b1;
        m_data_out  = 8'hEE;
        saw_rsp     = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_400);
            m_done = 1'b0;
            if (|rsp_valid) saw_rsp = 1'b1;
        end
        checkOutput("rst_no_rsp", 64'(saw_rsp), 64'd0);
        applyStimulus(0, 1'b1, 1'b0, 7'h01, 8'h01);
        applyStimulus(1, 1'b1, 1'b0, 7'h02, 8'h02);
        waitFor(0, 20, "rst_first");
        checkOutput("rst_first_grant", 64'(req_ready), 64'h1);
        req_valid = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
